// File: rtl/interrupt_arbiter.sv
// ----------------------------------------------------------------------------
// interrupt_arbiter
//
// N-channel interrupt front end. Each active-low request line passes through a
// two-flop synchroniser plus one delay flop. Each channel is then captured as
// either a falling edge or a low level. Masks and non-maskable overrides are
// applied next, and the lowest-numbered eligible channel wins. The winning
// vector is presented and held through an ack / handled handshake with the
// control logic.
//
// Ports
//   fclk         in   1       system clock, all state updates on posedge
//   rstAll       in   1       synchronous active-high reset
//   haltAll      in   1       1 = freeze the FSM (intAck / intHandled ignored)
//   int_l        in   NUM_CH  asynchronous active-low request lines
//   edge_mode    in   NUM_CH  1 = falling-edge capture, 0 = level (low)
//   mask         in   NUM_CH  1 = channel masked, unless its NMI_MASK bit is set
//   intAck       in   1       control logic accepts the presented vector
//   intHandled   in   1       service routine entry complete
//   activeValid  out  1       vector presented / being serviced
//   activeInt    out  VEC_W   index of the presented channel
//   pending      out  NUM_CH  raw per-channel pending, before the mask
// ----------------------------------------------------------------------------
module interrupt_arbiter #(
  parameter int                NUM_CH   = 4,
  parameter int                VEC_W    = 2,
  parameter logic [NUM_CH-1:0] NMI_MASK = 4'b0001
) (
  input  logic              fclk,
  input  logic              rstAll,
  input  logic              haltAll,
  input  logic [NUM_CH-1:0] int_l,
  input  logic [NUM_CH-1:0] edge_mode,
  input  logic [NUM_CH-1:0] mask,
  input  logic              intAck,
  input  logic              intHandled,
  output logic              activeValid,
  output logic [VEC_W-1:0]  activeInt,
  output logic [NUM_CH-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // Synchroniser, delay flop, edge-pending and last-seen mode.
  logic [NUM_CH-1:0] s1_q, s2_q, s3_q;
  logic [NUM_CH-1:0] epend_q, epend_d;
  logic [NUM_CH-1:0] mode_q;

  // FSM state and registered outputs.
  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [VEC_W-1:0]  vec_q, vec_d;

  // Combinational helpers.
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] ack_clr;
  logic [VEC_W-1:0]  win;
  logic              any_elig;
  logic              ack_accept;

  // The sync / capture path keeps running while haltAll is high, so an edge
  // arriving during a freeze is still latched.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse s1->s2->s3 into one stage.
  always_ff @(posedge fclk) begin
    // The mode register follows edge_mode even in reset. A mode change that
    // happens across reset release is then not seen as a toggle.
    mode_q <= edge_mode;
    if (rstAll) begin
      s1_q    <= '1;
      s2_q    <= '1;
      s3_q    <= '1;
      epend_q <= '0;
    end else begin
      s1_q    <= int_l;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      epend_q <= epend_d;
    end
  end

  // A falling edge is visible one stage after the synchroniser output goes low.
  assign fall    = s3_q & ~s2_q;
  assign pending = (edge_mode & epend_q) | (~edge_mode & ~s2_q);
  assign elig    = pending & (~mask | NMI_MASK);

  // Lowest index wins. Scanning from the top lets the last assignment stick.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    win      = '0;
    any_elig = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win      = VEC_W'(i);
        any_elig = 1'b1;
      end
    end
  end

  // An ack counts only in REQ, when not frozen, and while the presented
  // channel is still eligible. In that case withdrawal takes precedence.
  assign ack_accept = (state_q == REQ) && !haltAll && elig[vec_q] && intAck;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ack_clr[i] = ack_accept && (vec_q == VEC_W'(i));
    end
  end

  // A new edge wins over an ack clear or a mode toggle in the same cycle.
  // Level-mode channels never accumulate edge-pending state.
  assign epend_d = (epend_q & ~ack_clr & ~(edge_mode ^ mode_q)) | (fall & edge_mode);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    vec_d   = vec_q;
    if (!haltAll) begin
      unique case (state_q)
        IDLE: begin
          if (any_elig) begin
            state_d = REQ;
            valid_d = 1'b1;
            vec_d   = win;
          end
        end
        REQ: begin
          // The vector is frozen: a higher-priority arrival does not preempt.
          if (!elig[vec_q]) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else if (intAck) begin
            state_d = SERVICE;
          end
        end
        SERVICE: begin
          // Mask or line changes are ignored here. Leaving via IDLE gives
          // the one-cycle bubble before the next request.
          if (intHandled) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge fclk) begin
    if (rstAll) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      vec_q   <= vec_d;
    end
  end

  assign activeValid = valid_q;
  assign activeInt   = vec_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// ----------------------------------------------------------------------------
// tb_interrupt_arbiter
//
// Self-checking bench for interrupt_arbiter. A behavioural reference model
// keeps a short history of sampled request lines, per-channel edge-pending
// bits and a phase number. A compare process checks every DUT output against
// the model on each falling clock edge. Directed scenarios add hand-computed
// literal expectations, and a randomized phase follows them.
// ----------------------------------------------------------------------------
module tb_interrupt_arbiter;

  localparam int              NUM_CH = 4;
  localparam int              VEC_W  = 2;
  localparam logic [NUM_CH-1:0] NMI  = 4'b0001;

  logic              fclk = 1'b0;
  logic              rstAll;
  logic              haltAll;
  logic [NUM_CH-1:0] int_l;
  logic [NUM_CH-1:0] edge_mode;
  logic [NUM_CH-1:0] mask;
  logic              intAck;
  logic              intHandled;
  logic              activeValid;
  logic [VEC_W-1:0]  activeInt;
  logic [NUM_CH-1:0] pending;

  int errors = 0;
  int checks = 0;

  interrupt_arbiter #(
    .NUM_CH  (NUM_CH),
    .VEC_W   (VEC_W),
    .NMI_MASK(NMI)
  ) dut (
    .fclk       (fclk),
    .rstAll     (rstAll),
    .haltAll    (haltAll),
    .int_l      (int_l),
    .edge_mode  (edge_mode),
    .mask       (mask),
    .intAck     (intAck),
    .intHandled (intHandled),
    .activeValid(activeValid),
    .activeInt  (activeInt),
    .pending    (pending)
  );

  always #5 fclk = ~fclk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------- model --
  // hist[0] is the newest sample of int_l and hist[2] the oldest. hist[1]
  // is the synchronised line the arbiter acts on.
  logic [NUM_CH-1:0] hist [3];
  logic [NUM_CH-1:0] m_ep;
  logic [NUM_CH-1:0] m_prev_mode;
  int                m_phase;   // 0 idle, 1 presented, 2 in service
  bit                m_valid;
  int                m_vec;
  bit                m_started = 1'b0;

  function automatic logic [NUM_CH-1:0] model_pending();
    logic [NUM_CH-1:0] p;
    for (int i = 0; i < NUM_CH; i++)
      p[i] = edge_mode[i] ? m_ep[i] : !hist[1][i];
    return p;
  endfunction

  function automatic int lowest(input logic [NUM_CH-1:0] v);
    for (int i = 0; i < NUM_CH; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge fclk) begin
    logic [NUM_CH-1:0] pend, elig;
    int acked;
    m_started = 1'b1;
    if (rstAll) begin
      for (int j = 0; j < 3; j++) hist[j] = '1;
      m_ep        = '0;
      m_prev_mode = edge_mode;
      m_phase     = 0;
      m_valid     = 1'b0;
      m_vec       = 0;
    end else begin
      pend  = model_pending();
      elig  = pend & (~mask | NMI);
      acked = -1;
      if (!haltAll) begin
        if (m_phase == 0) begin
          if (elig != '0) begin
            m_phase = 1;
            m_valid = 1'b1;
            m_vec   = lowest(elig);
          end
        end else if (m_phase == 1) begin
          if (!elig[m_vec]) begin
            m_phase = 0;
            m_valid = 1'b0;
          end else if (intAck) begin
            m_phase = 2;
            acked   = m_vec;
          end
        end else begin
          if (intHandled) begin
            m_phase = 0;
            m_valid = 1'b0;
          end
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        bit fell, keep;
        fell    = hist[2][i] && !hist[1][i] && edge_mode[i];
        keep    = m_ep[i] && (edge_mode[i] == m_prev_mode[i]) && (acked != i);
        m_ep[i] = fell || keep;
      end
      m_prev_mode = edge_mode;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = int_l;
    end
  end

  // Single compare process: outputs are stable half a period after posedge.
  always @(negedge fclk) begin
    if (m_started) begin
      check("model_valid",   32'(activeValid), 32'(m_valid));
      check("model_vec",     32'(activeInt),   32'(m_vec));
      check("model_pending", 32'(pending),     32'(model_pending()));
    end
  end

  // ------------------------------------------------------------- stimulus --
  // Inputs change 1 time unit after the falling edge, clear of both the
  // compare sampling point and the active edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge fclk);
      #1;
    end
  endtask

  task automatic quiet();
    haltAll    = 1'b0;
    int_l      = '1;
    mask       = '0;
    intAck     = 1'b0;
    intHandled = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rstAll = 1'b1;
    step(2);
    rstAll = 1'b0;
  endtask

  initial begin
    rstAll     = 1'b1;
    edge_mode  = '0;
    quiet();

    // 1: reset with all lines asserted.
    int_l = '0;
    step(2);
    check("rst_valid",   32'(activeValid), 32'd0);
    check("rst_vec",     32'(activeInt),   32'd0);
    check("rst_pending", 32'(pending),     32'd0);
    rstAll = 1'b0;
    int_l  = '1;
    step(1);
    check("rel_pending", 32'(pending),     32'd0);
    check("rel_valid",   32'(activeValid), 32'd0);

    // 2: edge latency on ch2.
    edge_mode = 4'b0100;
    do_reset();
    int_l[2] = 1'b0;
    step(1);                                     // edge k
    check("edge_pend_k",  32'(pending[2]), 32'd0);
    step(1);                                     // edge k+1
    check("edge_pend_k1", 32'(pending[2]), 32'd0);
    int_l[2] = 1'b1;
    step(1);                                     // edge k+2
    check("edge_pend_k2",  32'(pending[2]),  32'd1);
    check("edge_valid_k2", 32'(activeValid), 32'd0);
    step(1);                                     // edge k+3
    check("edge_valid_k3", 32'(activeValid), 32'd1);
    check("edge_vec_k3",   32'(activeInt),   32'd2);
    intAck = 1'b1;
    step(1);
    intAck = 1'b0;
    check("edge_ack_pend",  32'(pending[2]),  32'd0);
    check("edge_ack_valid", 32'(activeValid), 32'd1);
    intHandled = 1'b1;
    step(1);
    intHandled = 1'b0;
    check("edge_handled", 32'(activeValid), 32'd0);

    // 3: priority without preemption.
    edge_mode = '0;
    do_reset();
    int_l[3] = 1'b0;
    step(3);
    check("prio_req_valid", 32'(activeValid), 32'd1);
    check("prio_req_vec",   32'(activeInt),   32'd3);
    int_l[1] = 1'b0;
    step(3);
    check("prio_nopreempt", 32'(activeInt), 32'd3);
    intAck = 1'b1;
    step(1);
    intAck = 1'b0;
    step(2);
    check("prio_service_vec", 32'(activeInt), 32'd3);
    intHandled = 1'b1;
    step(1);
    intHandled = 1'b0;
    check("prio_bubble", 32'(activeValid), 32'd0);
    step(1);
    check("prio_next_valid", 32'(activeValid), 32'd1);
    check("prio_next_vec",   32'(activeInt),   32'd1);

    // 4: masking with the NMI override on ch0.
    do_reset();
    mask  = 4'b1111;
    int_l = 4'b1100;
    step(2);
    check("mask_pending", 32'(pending), 32'b0011);
    step(1);
    check("mask_nmi_valid", 32'(activeValid), 32'd1);
    check("mask_nmi_vec",   32'(activeInt),   32'd0);
    int_l[0] = 1'b1;
    step(3);
    check("mask_withdraw", 32'(activeValid), 32'd0);
    step(2);
    check("mask_ch1_blocked", 32'(activeValid), 32'd0);
    check("mask_ch1_pending", 32'(pending),     32'b0010);
    mask = 4'b1101;
    step(1);
    check("mask_ch1_valid", 32'(activeValid), 32'd1);
    check("mask_ch1_vec",   32'(activeInt),   32'd1);

    // 5: withdrawal of a level request before the ack.
    do_reset();
    int_l[3] = 1'b0;
    step(3);
    check("wd_req", 32'(activeValid), 32'd1);
    int_l[3] = 1'b1;
    step(2);
    check("wd_k1", 32'(activeValid), 32'd1);
    step(1);
    check("wd_k2", 32'(activeValid), 32'd0);

    // 6: haltAll freeze, then edge set racing the ack clear.
    edge_mode = 4'b0100;
    do_reset();
    int_l[3] = 1'b0;
    step(3);
    check("halt_req_vec", 32'(activeInt), 32'd3);
    haltAll  = 1'b1;
    intAck   = 1'b1;
    int_l[2] = 1'b0;
    step(2);
    int_l[2] = 1'b1;
    step(1);
    check("halt_edge_pend", 32'(pending[2]), 32'd1);
    check("halt_frozen",    32'(activeInt),  32'd3);
    step(1);
    haltAll  = 1'b0;
    intAck   = 1'b0;
    int_l[3] = 1'b1;
    step(3);
    check("halt_ack_ignored", 32'(activeValid), 32'd0);
    step(1);
    check("race_req_vec", 32'(activeInt), 32'd2);
    int_l[2] = 1'b0;
    step(2);
    int_l[2] = 1'b1;
    intAck   = 1'b1;
    step(1);
    intAck   = 1'b0;
    check("race_pend_kept", 32'(pending[2]), 32'd1);
    intHandled = 1'b1;
    step(1);
    intHandled = 1'b0;
    step(1);
    check("race_rerequest", 32'(activeValid), 32'd1);

    // Randomized phase.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) int_l[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) edge_mode[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 19) == 0) mask = NUM_CH'($urandom_range(0, 15));
      intAck     = ($urandom_range(0, 2) == 0);
      intHandled = ($urandom_range(0, 3) == 0);
      haltAll    = ($urandom_range(0, 7) == 0);
      rstAll     = ($urandom_range(0, 299) == 0);
      step(1);
    end
    quiet();
    rstAll = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
